// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: default widths, reset PC,
// bubble instruction and next-PC select encoding.
package if_stage_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] SEL_SEQ  = 2'd0;
  localparam logic [1:0] SEL_BR   = 2'd1;
  localparam logic [1:0] SEL_JMP  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

endpackage

// File: rtl/if_stage_add4.sv
// PC incrementer: o_sum = i_a + 4, wrapping modulo 2^SIZE.
module if_stage_add4 #(
  parameter int unsigned SIZE = 32
) (
  input  logic [SIZE-1:0] i_a,
  output logic [SIZE-1:0] o_sum
);

  assign o_sum = i_a + SIZE'(4);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, and the IF/ID pipeline
// register with a misaligned-redirect tag that follows the first fetched word.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(DEF_NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic [WIDTH-1:0] i_imem_rdata,
  input  logic             i_imem_ready,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_if_id_instr,
  output logic [WIDTH-1:0] o_if_id_pc_plus4,
  output logic             o_if_id_valid,
  output logic             o_if_id_misalign
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc_plus4;
  logic             r_valid;
  logic             r_misalign;
  logic             r_pend;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_pc_d;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_instr_d;
  logic [WIDTH-1:0] w_pc_plus4_d;
  logic             w_valid_d;
  logic             w_misalign_d;
  logic             w_pend_d;
  logic             w_redirect;
  logic             w_target_mis;
  logic [1:0]       w_sel;

  if_stage_add4 #(
    .SIZE (WIDTH)
  ) u_add4 (
    .i_a   (r_pc),
    .o_sum (w_pc_plus4)
  );

  always_comb begin
    w_redirect   = i_branch_taken | i_jump;
    w_target     = i_branch_taken ? i_branch_target : i_jump_target;
    w_target_mis = |w_target[1:0];

    if (i_branch_taken)                w_sel = SEL_BR;
    else if (i_jump)                   w_sel = SEL_JMP;
    else if (i_stall || !i_imem_ready) w_sel = SEL_HOLD;
    else                               w_sel = SEL_SEQ;

    w_pc_d = r_pc;
    unique case (w_sel)
      SEL_BR:   w_pc_d = {i_branch_target[WIDTH-1:2], 2'b00};
      SEL_JMP:  w_pc_d = {i_jump_target[WIDTH-1:2], 2'b00};
      SEL_HOLD: w_pc_d = r_pc;
      SEL_SEQ:  w_pc_d = w_pc_plus4;
      default:  w_pc_d = r_pc;
    endcase
  end

  // A redirect drops the in-flight fetch, so it bubbles IF/ID just like a flush.
  always_comb begin
    w_instr_d    = r_instr;
    w_pc_plus4_d = r_pc_plus4;
    w_valid_d    = r_valid;
    w_misalign_d = r_misalign;
    w_pend_d     = r_pend;

    if (i_flush || w_redirect || (!i_stall && !i_imem_ready)) begin
      w_instr_d    = NOP_INSTR;
      w_valid_d    = 1'b0;
      w_misalign_d = 1'b0;
    end else if (!i_stall) begin
      w_instr_d    = i_imem_rdata;
      w_pc_plus4_d = w_pc_plus4;
      w_valid_d    = 1'b1;
      w_misalign_d = r_pend;
      w_pend_d     = 1'b0;
    end

    if (w_redirect) w_pend_d = w_target_mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_pc       <= w_pc_d;
      r_instr    <= w_instr_d;
      r_pc_plus4 <= w_pc_plus4_d;
      r_valid    <= w_valid_d;
      r_misalign <= w_misalign_d;
      r_pend     <= w_pend_d;
    end
  end

  assign o_imem_addr      = r_pc;
  assign o_pc             = r_pc;
  assign o_if_id_instr    = r_instr;
  assign o_if_id_pc_plus4 = r_pc_plus4;
  assign o_if_id_valid    = r_valid;
  assign o_if_id_misalign = r_misalign;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: expected IF/ID entries are queued as each
// fetch is driven and compared when they appear on the pipeline register.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, br, jmp, rdy;
  logic [31:0] bt, jt, rdata;
  logic [31:0] imem_addr, pc, id_instr, id_pc4;
  logic        id_valid, id_mis;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_pc;
  logic        m_pend;
  exp_t        last;
  logic        last_valid;

  if_stage u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_branch_taken   (br),
    .i_branch_target  (bt),
    .i_jump           (jmp),
    .i_jump_target    (jt),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (rdata),
    .i_imem_ready     (rdy),
    .o_pc             (pc),
    .o_if_id_instr    (id_instr),
    .o_if_id_pc_plus4 (id_pc4),
    .o_if_id_valid    (id_valid),
    .o_if_id_misalign (id_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; br = 0; jmp = 0; rdy = 0;
    bt = '0; jt = '0; rdata = '0;
  endtask

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic cyc(input string tag, input logic st, input logic fl, input logic b,
                     input logic [31:0] btgt, input logic j, input logic [31:0] jtgt,
                     input logic r, input logic [31:0] rd);
    logic [31:0] tgt;
    logic        redir;
    int          kind;  // 0 bubble, 1 hold, 2 load
    exp_t        e;
    @(negedge clk);
    stall = st; flush = fl; br = b; bt = btgt; jmp = j; jt = jtgt; rdy = r; rdata = rd;
    #1;
    check_eq({tag, ".addr"}, imem_addr, m_pc);
    redir = b | j;
    tgt   = b ? btgt : jtgt;
    if (fl || redir) kind = 0;
    else if (st)     kind = 1;
    else if (!r)     kind = 0;
    else begin
      kind = 2;
      sb.push_back('{instr: rd, pc4: m_pc + 32'd4, mis: m_pend});
      m_pend = 1'b0;
    end
    if (redir) begin
      m_pc   = {tgt[31:2], 2'b00};
      m_pend = |tgt[1:0];
    end else if (!(st || !r)) begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".pc"}, pc, m_pc);
    case (kind)
      0: begin
        check_eq({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
        check_eq({tag, ".instr"}, id_instr, NOP);
        check_eq({tag, ".mis"}, {31'b0, id_mis}, 32'd0);
        last.instr = NOP; last.mis = 1'b0; last_valid = 1'b0;
      end
      1: begin
        check_eq({tag, ".hold_valid"}, {31'b0, id_valid}, {31'b0, last_valid});
        check_eq({tag, ".hold_instr"}, id_instr, last.instr);
        check_eq({tag, ".hold_pc4"}, id_pc4, last.pc4);
      end
      default: begin
        e = sb.pop_front();
        check_eq({tag, ".valid"}, {31'b0, id_valid}, 32'd1);
        check_eq({tag, ".instr"}, id_instr, e.instr);
        check_eq({tag, ".pc4"}, id_pc4, e.pc4);
        check_eq({tag, ".mis"}, {31'b0, id_mis}, {31'b0, e.mis});
        last = e; last_valid = 1'b1;
      end
    endcase
  endtask

  task automatic seq(input string tag, input logic [31:0] rd);
    cyc(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rd);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".pc"}, pc, 32'h0);
    check_eq({tag, ".instr"}, id_instr, NOP);
    check_eq({tag, ".pc4"}, id_pc4, 32'h0);
    check_eq({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
    check_eq({tag, ".mis"}, {31'b0, id_mis}, 32'd0);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 1'b0;
    last = '{instr: NOP, pc4: 32'h0, mis: 1'b0}; last_valid = 1'b0;
    sb.delete();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

    // Sequential fetch, then a two-cycle stall at pc=8.
    seq("seqA", 32'hAAAA_0001);
    seq("seqB", 32'hBBBB_0002);
    cyc("stall1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0001);
    cyc("stall2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0002);
    seq("seqC", 32'hCCCC_0003);

    // Branch overrides stall; next fetch lands at the target.
    cyc("brst", 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 32'hDEAD_0003);
    seq("atbr", 32'hDDDD_0004);

    // Misaligned jump tags only the first instruction from the target.
    cyc("jmis", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0202, 1'b1, 32'hDEAD_0004);
    seq("mis1", 32'hEEEE_0005);
    seq("mis0", 32'hFFFF_0006);

    // Memory not ready: pc holds, bubbles.
    for (int i = 0; i < 3; i++)
      cyc("nrdy", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hDEAD_0005);
    seq("resume", 32'h1111_0007);

    // Flush alone advances pc; flush with stall holds pc; both bubble IF/ID.
    cyc("flush", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0006);
    cyc("flst", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0007);
    seq("postfl", 32'h2222_0008);

    // Branch beats jump; redirect with memory not ready.
    cyc("brjmp", 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
    seq("at400", 32'h3333_0009);

    // PC+4 wraps at the top of the address space.
    cyc("jtop", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    seq("wrap", 32'h4444_000A);
    seq("after", 32'h5555_000B);

    // Pending misalign is cleared by an asynchronous reset mid-stream.
    cyc("jmis2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b1, 32'h0);
    seq("prerst", 32'h6666_000C);
    cyc("jmis3", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0021, 1'b1, 32'h0);
    @(negedge clk);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check_reset_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seq("postrst", 32'h7777_000D);
    seq("postrst2", 32'h8888_000E);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
